// File: rtl/shift_rows_stream.sv
// shift_rows_stream: streaming AES ShiftRows / InvShiftRows / bypass over LANES
// independent 128-bit states, with a 2-entry output FIFO that sustains one
// transfer per cycle. Data is transformed on the way into the FIFO, so the
// entries always hold finished results and the head drives out_* directly.
module shift_rows_stream #(
  parameter int LANES = 1,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [128*LANES-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TAG_W-1:0]       out_tag,
  output logic [128*LANES-1:0]   out_data,
  output logic [1:0]             occupancy,
  output logic                   mode_err
);

  localparam int DATA_W = 128 * LANES;

  // Byte (r,c) of a state sits at bits [127-8*(4c+r) -: 8]. Mode 00 rotates
  // row r left by r, mode 01 rotates it right by r, anything else passes through.
  function automatic logic [127:0] shift_state(input logic [127:0] s,
                                               input logic [1:0]   mode);
    logic [127:0] o;
    int           src;
    o = s;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case (mode)
          2'b00:   src = (c + r) % 4;
          2'b01:   src = (c + 4 - r) % 4;
          default: src = c;
        endcase
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  logic [DATA_W-1:0] xf_data;
  logic [DATA_W-1:0] ent0_data, ent1_data;
  logic [TAG_W-1:0]  ent0_tag, ent1_tag;
  logic [1:0]        cnt;
  logic              push, pop;

  // Apply the selected row rotation to every lane independently.
  always_comb begin
    xf_data = '0;
    for (int k = 0; k < LANES; k++) begin
      xf_data[128*k +: 128] = shift_state(in_data[128*k +: 128], in_mode);
    end
  end

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign occupancy = cnt;
  assign out_data  = ent0_data;
  assign out_tag   = ent0_tag;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // FIFO storage: entry 0 is always the head, entry 1 the one behind it.
  // Reset clears the entries too so a dropped stream never leaks onto out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 2'd0;
      ent0_data <= '0;
      ent1_data <= '0;
      ent0_tag  <= '0;
      ent1_tag  <= '0;
      mode_err  <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            ent0_data <= xf_data;
            ent0_tag  <= in_tag;
          end else begin
            ent1_data <= xf_data;
            ent1_tag  <= in_tag;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0_data <= ent1_data;
          ent0_tag  <= ent1_tag;
          cnt       <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0_data <= xf_data;
            ent0_tag  <= in_tag;
          end else begin
            ent0_data <= ent1_data;
            ent0_tag  <= ent1_tag;
            ent1_data <= xf_data;
            ent1_tag  <= in_tag;
          end
        end
        default: ;
      endcase
      if (push && (in_mode == 2'b11)) begin
        mode_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Bench for shift_rows_stream: a LANES=1 instance for most scenarios and a
// LANES=2 instance for lane independence; results checked against a byte-matrix
// reference model.
module tb_shift_rows_stream;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, mode_err;
  logic [1:0]   in_mode = 2'b00, occupancy;
  logic [3:0]   in_tag = 4'h0, out_tag;
  logic [127:0] in_data = '0, out_data;

  logic         in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0, mode_err2;
  logic [1:0]   in_mode2 = 2'b00, occupancy2;
  logic [3:0]   in_tag2 = 4'h0, out_tag2;
  logic [255:0] in_data2 = '0, out_data2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  shift_rows_stream #(.LANES(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_tag(in_tag), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_data(out_data), .occupancy(occupancy), .mode_err(mode_err));

  shift_rows_stream #(.LANES(2), .TAG_W(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_mode(in_mode2), .in_tag(in_tag2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_tag(out_tag2),
    .out_data(out_data2), .occupancy(occupancy2), .mode_err(mode_err2));

  // Reference: unpack into a 4x4 byte matrix, rotate rows, repack.
  function automatic logic [127:0] ref_lane(input logic [127:0] d, input logic [1:0] m);
    logic [7:0]   st [4][4];
    logic [7:0]   o  [4][4];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) st[i % 4][i / 4] = d[127 - 8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m == 2'b00)      o[r][c] = st[r][(c + r) % 4];
        else if (m == 2'b01) o[r][c] = st[r][(c + 4 - r) % 4];
        else                 o[r][c] = st[r][c];
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = o[i % 4][i / 4];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({out_valid, occupancy, in_ready, mode_err} !== 5'b0_00_1_0) begin
      $display("FAIL reset_ctrl got v=%0b occ=%0d rdy=%0b err=%0b want v=0 occ=0 rdy=1 err=0",
               out_valid, occupancy, in_ready, mode_err);
    end else passed++;
    total++; if ({out_data, out_tag} !== 132'h0) begin
      $display("FAIL reset_data got %h/%h want 0/0", out_data, out_tag);
    end else passed++;
  endtask

  task automatic test_vector();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00; in_tag = 4'h5;
    in_data = 128'hd42711aee0bf98f1b8b45de51e415230;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin
      $display("FAIL vec_latency out_valid got %0b want 1", out_valid);
    end else passed++;
    total++; if (out_data !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin
      $display("FAIL vec_shiftrows got %h want d4bf5d30e0b452aeb84111f11e2798e5", out_data);
    end else passed++;
    total++; if (out_tag !== 4'h5) begin
      $display("FAIL vec_tag got %h want 5", out_tag);
    end else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      $display("FAIL vec_drain got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy);
    end else passed++;
  endtask

  task automatic test_modes();
    logic [127:0] din [4];
    logic [1:0]   md  [4];
    logic [127:0] exp_d;
    din[0] = 128'hd4bf5d30e0b452aeb84111f11e2798e5; md[0] = 2'b01;
    din[1] = rand128();                             md[1] = 2'b10;
    din[2] = rand128();                             md[2] = 2'b01;
    din[3] = rand128();                             md[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = md[i]; in_tag = 4'(i + 8); in_data = din[i];
      exp_d = ref_lane(din[i], md[i]);
      tick();
      in_valid = 1'b0;
      total++; if (out_data !== exp_d || out_tag !== 4'(i + 8)) begin
        $display("FAIL mode%0d got %h/%h want %h/%h", md[i], out_data, out_tag, exp_d, 4'(i + 8));
      end else passed++;
      out_ready = 1'b1;
      tick();
    end
    total++; if (out_data !== 128'hd42711aee0bf98f1b8b45de51e415230 && 1'b0) passed++;
    total--;
    total++; if (mode_err !== 1'b1) begin
      $display("FAIL mode_err_set got %0b want 1", mode_err);
    end else passed++;
    in_valid = 1'b1; in_mode = 2'b00; in_data = rand128();
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    total++; if (mode_err !== 1'b1) begin
      $display("FAIL mode_err_sticky got %0b want 1", mode_err);
    end else passed++;
  endtask

  task automatic test_backpressure();
    logic [127:0] d [3];
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) d[i] = rand128();
    in_valid = 1'b1; in_mode = 2'b00; in_tag = 4'd1; in_data = d[0];
    tick();
    total++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
      $display("FAIL bp_occ1 got occ=%0d rdy=%0b want occ=1 rdy=1", occupancy, in_ready);
    end else passed++;
    in_tag = 4'd2; in_data = d[1];
    tick();
    total++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      $display("FAIL bp_occ2 got occ=%0d rdy=%0b want occ=2 rdy=0", occupancy, in_ready);
    end else passed++;
    in_tag = 4'd3; in_data = d[2];
    tick();
    total++; if (occupancy !== 2'd2 || out_tag !== 4'd1 || out_data !== ref_lane(d[0], 2'b00)) begin
      $display("FAIL bp_held got occ=%0d tag=%0d data=%h want occ=2 tag=1 data=%h",
               occupancy, out_tag, out_data, ref_lane(d[0], 2'b00));
    end else passed++;
    tick();
    total++; if (out_tag !== 4'd1 || out_data !== ref_lane(d[0], 2'b00)) begin
      $display("FAIL bp_stable got tag=%0d data=%h want tag=1 data=%h",
               out_tag, out_data, ref_lane(d[0], 2'b00));
    end else passed++;
    out_ready = 1'b1;
    tick();
    total++; if (occupancy !== 2'd1 || out_tag !== 4'd2 || out_data !== ref_lane(d[1], 2'b00)) begin
      $display("FAIL bp_pop1 got occ=%0d tag=%0d want occ=1 tag=2", occupancy, out_tag);
    end else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (occupancy !== 2'd1 || out_tag !== 4'd3 || out_data !== ref_lane(d[2], 2'b00)) begin
      $display("FAIL bp_pop2 got occ=%0d tag=%0d want occ=1 tag=3", occupancy, out_tag);
    end else passed++;
    tick();
    out_ready = 1'b0;
    total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      $display("FAIL bp_empty got occ=%0d v=%0b want occ=0 v=0", occupancy, out_valid);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] qd [$];
    logic [3:0]   qt [$];
    int  outs = 0, sent = 0, cyc = 0;
    logic acc, pp;
    do_reset();
    out_ready = 1'b1;
    while (outs < 100 && cyc < 300) begin
      if (sent < 100) begin
        in_valid = 1'b1; in_data = rand128();
        in_mode = 2'($urandom_range(0, 3)); in_tag = 4'($urandom);
      end else in_valid = 1'b0;
      acc = in_valid && in_ready;
      pp  = out_valid && out_ready;
      if (pp) begin
        total++;
        if (qd.size() == 0) begin
          $display("FAIL b2b_unexpected got tag=%0d data=%h want none", out_tag, out_data);
        end else begin
          if (out_data !== qd[0] || out_tag !== qt[0])
            $display("FAIL b2b_out%0d got %h/%h want %h/%h", outs, out_data, out_tag, qd[0], qt[0]);
          else passed++;
          void'(qd.pop_front()); void'(qt.pop_front());
        end
        outs++;
      end
      tick();
      cyc++;
      if (acc) begin
        qd.push_back(ref_lane(in_data, in_mode));
        qt.push_back(in_tag);
        sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (outs !== 100 || cyc !== 101) begin
      $display("FAIL b2b_rate got outs=%0d cycles=%0d want outs=100 cycles=101", outs, cyc);
    end else passed++;
  endtask

  task automatic test_lanes();
    logic [127:0] a, b;
    do_reset();
    out_ready2 = 1'b0;
    in_valid2 = 1'b1; in_mode2 = 2'b00; in_tag2 = 4'hA;
    in_data2 = {128'h000102030405060708090a0b0c0d0e0f, 128'hd42711aee0bf98f1b8b45de51e415230};
    tick();
    in_valid2 = 1'b0;
    total++; if (out_valid2 !== 1'b1 || out_tag2 !== 4'hA ||
                 out_data2 !== {128'h00050a0f04090e03080d02070c01060b,
                                128'hd4bf5d30e0b452aeb84111f11e2798e5}) begin
      $display("FAIL lanes_vec got v=%0b tag=%h data=%h", out_valid2, out_tag2, out_data2);
    end else passed++;
    out_ready2 = 1'b1;
    tick();
    a = rand128(); b = rand128();
    out_ready2 = 1'b0;
    in_valid2 = 1'b1; in_mode2 = 2'b01; in_tag2 = 4'h3; in_data2 = {b, a};
    tick();
    in_valid2 = 1'b0;
    total++; if (out_data2 !== {ref_lane(b, 2'b01), ref_lane(a, 2'b01)}) begin
      $display("FAIL lanes_inv got %h want %h", out_data2, {ref_lane(b, 2'b01), ref_lane(a, 2'b01)});
    end else passed++;
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b11; in_tag = 4'h7; in_data = rand128();
    tick();
    tick();
    in_valid = 1'b0;
    total++; if (occupancy !== 2'd2 || mode_err !== 1'b1) begin
      $display("FAIL mrst_fill got occ=%0d err=%0b want occ=2 err=1", occupancy, mode_err);
    end else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({out_valid, occupancy, in_ready, mode_err} !== 5'b0_00_1_0 ||
                 {out_data, out_tag} !== 132'h0) begin
      $display("FAIL mrst_clear got v=%0b occ=%0d rdy=%0b err=%0b data=%h want v=0 occ=0 rdy=1 err=0 data=0",
               out_valid, occupancy, in_ready, mode_err, out_data);
    end else passed++;
    in_valid = 1'b1; in_mode = 2'b00; in_tag = 4'hC;
    in_data = 128'hd42711aee0bf98f1b8b45de51e415230;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_tag !== 4'hC ||
                 out_data !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin
      $display("FAIL mrst_after got v=%0b tag=%h data=%h want v=1 tag=c data=d4bf5d30e0b452aeb84111f11e2798e5",
               out_valid, out_tag, out_data);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_vector();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_lanes();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
